// File: rtl/sampler_pkg.sv
// Shared definitions for the sample recorder and its companion player core:
// the take-state encoding and the millivolt-to-fixed-point conversion.
package sampler_pkg;

  // Recorder take state.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    FULL   = 2'd2
  } rec_state_t;

  // Convert a millivolt constant into the sample fixed-point format.
  function automatic int from_mv(input int mv, input int fp_offset);
    return mv <<< fp_offset;
  endfunction

endpackage

// File: rtl/sample_recorder_if.sv
// Read-back port of a recorded take. The player side (master) drives the
// address; the recorder side (slave) answers with data one cycle later and
// publishes the length of the last completed take and its busy flag.
interface sample_recorder_if #(
  parameter int W         = 16,
  parameter int N_SAMPLES = 1680
);

  localparam int AW = $clog2(N_SAMPLES);
  localparam int LW = AW + 1;

  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic [LW-1:0] rec_len;
  logic          rec_busy;

  modport master (
    output rd_addr,
    input  rd_data,
    input  rec_len,
    input  rec_busy
  );

  modport slave (
    input  rd_addr,
    output rd_data,
    output rec_len,
    output rec_busy
  );

endinterface

// File: rtl/schmitt_gate.sv
// Hysteretic gate detector. The level goes high at or above HI, low below LO,
// and holds in between. rise/fall are single-strobe pulses that coincide with
// the strobe on which the level changes, so callers can act on that strobe.
module schmitt_gate #(
  parameter int                   W  = 16,
  parameter logic signed [W-1:0]  HI = W'(4000),
  parameter logic signed [W-1:0]  LO = W'(2000)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stb,
  input  logic [W-1:0] in,
  output logic         level,
  output logic         rise,
  output logic         fall
);

  logic level_nxt;

  // Next tracker level from the signed input against both thresholds.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves level_nxt
    // unassigned; a missing default here would infer a latch.
    level_nxt = level;
    if ($signed(in) >= HI) begin
      level_nxt = 1'b1;
    end else if ($signed(in) < LO) begin
      level_nxt = 1'b0;
    end
  end

  assign rise = stb & ~level &  level_nxt;
  assign fall = stb &  level & ~level_nxt;

  // Tracker register; starts low so a gate already high at the first strobe
  // after reset is reported as a rise.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (!rst_n) begin
      level <= 1'b0;
    end else if (stb) begin
      level <= level_nxt;
    end
  end

endmodule

// File: rtl/sample_recorder.sv
// Gate-driven audio recorder. While the gate on sample_in1 is high, every
// DECIMATE-th strobed sample of sample_in0 is written into on-chip RAM. The
// finished take is exposed through a registered read port for a player core.
module sample_recorder
  import sampler_pkg::*;
#(
  parameter int W          = 16,
  parameter int FP_OFFSET  = 2,
  parameter int N_SAMPLES  = 1680,
  parameter int DECIMATE   = 2,
  parameter int TRIG_HI_MV = 1000,
  parameter int TRIG_LO_MV = 500,
  parameter int GATE_MV    = 5000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_stb,
  input  logic [W-1:0]     sample_in0,
  input  logic [W-1:0]     sample_in1,
  input  logic [W-1:0]     sample_in2,
  input  logic [W-1:0]     sample_in3,
  output logic [W-1:0]     sample_out0,
  output logic [W-1:0]     sample_out1,
  output logic [W-1:0]     sample_out2,
  output logic [W-1:0]     sample_out3,
  input  logic [7:0]       jack,
  sample_recorder_if.slave rd_if
);

  localparam int AW = $clog2(N_SAMPLES);
  localparam int LW = AW + 1;
  localparam int DW = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;

  localparam logic signed [W-1:0] TRIG_HI    = W'(from_mv(TRIG_HI_MV, FP_OFFSET));
  localparam logic signed [W-1:0] TRIG_LO    = W'(from_mv(TRIG_LO_MV, FP_OFFSET));
  localparam logic        [W-1:0] GATE_LEVEL = W'(from_mv(GATE_MV, FP_OFFSET));
  localparam logic       [LW-1:0] FULL_LEN   = LW'(N_SAMPLES);
  localparam logic       [DW-1:0] DIV_LAST   = DW'(DECIMATE - 1);

  // Jack detect carries no information for this core.
  logic unused_jack;
  assign unused_jack = ^jack;

  rec_state_t    state_q, state_nxt;
  logic          gate_level, gate_rise, gate_fall;
  logic [LW-1:0] wr_ptr_q, wr_ptr_inc, wr_ptr_after;
  logic [DW-1:0] div_q;
  logic [LW-1:0] rec_len_q;
  logic          write_en, hit_full;
  logic          busy_nxt, busy_q;
  logic [W-1:0]  out1_nxt;

  logic [W-1:0]  mem [N_SAMPLES];
  logic [W-1:0]  ram_q;
  logic          in_range_q;

  schmitt_gate #(
    .W  (W),
    .HI (TRIG_HI),
    .LO (TRIG_LO)
  ) u_gate (
    .clk   (clk),
    .rst_n (rst_n),
    .stb   (sample_stb),
    .in    (sample_in1),
    .level (gate_level),
    .rise  (gate_rise),
    .fall  (gate_fall)
  );

  // A write happens on recording strobes where the decimator is at phase 0.
  // wr_ptr_after is the pointer including that write, which is what a take
  // ending on this same strobe must report as its length.
  assign write_en     = sample_stb && (state_q == RECORD) && (div_q == '0);
  assign wr_ptr_inc   = wr_ptr_q + LW'(1);
  assign wr_ptr_after = write_en ? wr_ptr_inc : wr_ptr_q;
  assign hit_full     = write_en && (wr_ptr_inc == FULL_LEN);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // FSM next state; transitions only on strobe. A fall on the strobe that
  // fills the RAM takes priority and ends the take in IDLE.
  always_comb begin
    state_nxt = state_q;
    if (sample_stb) begin
      unique case (state_q)
        IDLE:    if (gate_rise) state_nxt = RECORD;
        RECORD: begin
          if (gate_fall)     state_nxt = IDLE;
          else if (hit_full) state_nxt = FULL;
        end
        FULL:    if (gate_fall) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM outputs, computed from the next state so the registered copies line
  // up with the state register.
  always_comb begin
    busy_nxt = (state_nxt == RECORD);
    out1_nxt = busy_nxt ? GATE_LEVEL : '0;
  end

  // Take bookkeeping: write pointer, decimation phase and completed length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      div_q     <= '0;
      rec_len_q <= '0;
    end else if (sample_stb) begin
      unique case (state_q)
        IDLE: begin
          if (gate_rise) begin
            wr_ptr_q  <= '0;
            div_q     <= '0;
            rec_len_q <= '0;
          end
        end
        RECORD: begin
          wr_ptr_q <= wr_ptr_after;
          div_q    <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
          if (gate_fall || hit_full) begin
            rec_len_q <= wr_ptr_after;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered jack outputs, refreshed on every strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_out0 <= '0;
      sample_out1 <= '0;
      sample_out2 <= '0;
      sample_out3 <= '0;
      busy_q      <= 1'b0;
    end else if (sample_stb) begin
      sample_out0 <= sample_in0;
      sample_out1 <= out1_nxt;
      sample_out2 <= sample_in2;
      sample_out3 <= sample_in3;
      busy_q      <= busy_nxt;
    end
  end

  // RAM write port.
  always_ff @(posedge clk) begin
    // NOTE: the sample RAM and its read register carry no reset; a reset
    // would stop them mapping onto a block RAM, and the take length already
    // masks any stale contents.
    if (write_en) begin
      mem[wr_ptr_q[AW-1:0]] <= sample_in0;
    end
  end

  // RAM read port, read-first against a same-cycle write.
  always_ff @(posedge clk) begin
    ram_q <= mem[rd_if.rd_addr];
  end

  // Validity of the read, judged against the take length at the read cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_range_q <= 1'b0;
    end else begin
      in_range_q <= (LW'(rd_if.rd_addr) < rec_len_q);
    end
  end

  assign rd_if.rd_data  = in_range_q ? ram_q : '0;
  assign rd_if.rec_len  = rec_len_q;
  assign rd_if.rec_busy = busy_q;

endmodule
